// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the control sequencer: state encoding, opcode and
// function-field constants, and the register-write decode.
package control_sequencer_pkg;

  // PREEMPT aliases WAIT_IN on the 3-bit state port; the preempt pulse tells them apart.
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC    = 4'd2,
    S_WAIT_MD = 4'd3,
    S_WAIT_HD = 4'd4,
    S_WB      = 4'd5,
    S_WAIT_IN = 4'd6,
    S_HALT    = 4'd7,
    S_PREEMPT = 4'd14
  } state_t;

  localparam logic [6:0] OP_R     = 7'd51;
  localparam logic [6:0] OP_LW    = 7'd3;
  localparam logic [6:0] OP_ADDI  = 7'd19;
  localparam logic [6:0] OP_BR    = 7'd99;
  localparam logic [6:0] OP_JAL   = 7'd111;
  localparam logic [6:0] OP_SW    = 7'd35;
  localparam logic [6:0] OP_IN    = 7'd55;
  localparam logic [6:0] OP_AUIPC = 7'd23;
  localparam logic [6:0] OP_HALT  = 7'd63;
  localparam logic [6:0] OP_HD_RD = 7'd62;
  localparam logic [6:0] OP_HD_WR = 7'd61;
  localparam logic [6:0] OP_WAIT  = 7'd60;

  localparam logic [2:0] F3_MD = 3'd3;
  localparam logic [2:0] F3_JR = 3'd7;

  localparam logic [6:0] F7_JR     = 7'd0;
  localparam logic [6:0] F7_JR_CTX = 7'd1;
  localparam logic [6:0] F7_JR_SO  = 7'd2;

  function automatic logic is_jr(input logic [2:0] fn3, input logic [6:0] fn7);
    return (fn3 == F3_JR) && ((fn7 == F7_JR) || (fn7 == F7_JR_CTX) || (fn7 == F7_JR_SO));
  endfunction

  // hd_fail marks a disk read that timed out, which must not write back.
  function automatic logic writes_reg(input logic [6:0] op, input logic [2:0] fn3,
                                      input logic [6:0] fn7, input logic hd_fail);
    logic w;
    w = 1'b0;
    case (op)
      OP_R:                            w = !is_jr(fn3, fn7);
      OP_LW, OP_ADDI, OP_JAL, OP_IN:   w = 1'b1;
      OP_HD_RD:                        w = !hd_fail;
      default:                         w = 1'b0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/control_sequencer_quantum_timer.sv
// User-mode preemption quantum: down-counter with reload, yield request and
// a sticky pending flag that the sequencer honours at its next fetch.
module quantum_timer #(
  parameter int QUANTUM = 1000,
  parameter int QW      = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic user_mode,
  input  logic reload,
  input  logic clear_pending,
  input  logic yield_req,
  output logic pending
);

  localparam logic [QW-1:0] RELOAD_VAL = QW'(QUANTUM);

  logic [QW-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count   <= RELOAD_VAL;
      pending <= 1'b0;
    end else if (reload) begin
      // A reload beats an expiry landing on the same cycle.
      count <= RELOAD_VAL;
      if (clear_pending) pending <= 1'b0;
    end else begin
      if (user_mode && (count != '0)) begin
        count <= count - 1'b1;
        if (count == QW'(1)) pending <= 1'b1;
      end
      if (yield_req) pending <= 1'b1;
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control FSM: fetch/decode/execute with mul/div, disk and
// switch-input waits, plus user-mode quantum preemption and sticky halt.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int QUANTUM = 1000,
  parameter int QW      = 16,
  parameter int MD_LAT  = 4,
  parameter int HD_TMO  = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] f3,
  input  logic [6:0] f7,
  input  logic       hd_ready,
  input  logic       in_valid,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic       hd_req,
  output logic       hd_we,
  output logic       in_ack,
  output logic       preempt,
  output logic       user_mode,
  output logic       halted,
  output logic       hd_err,
  output logic [2:0] state
);

  localparam int TW = (HD_TMO < 2) ? 1 : $clog2(HD_TMO + 1);

  state_t        st, st_nx;
  logic [3:0]    md_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          hd_fail;
  logic          pending;
  logic          in_wb, jr_ctx, jr_so, tmo_hit;

  assign in_wb   = (st == S_WB);
  assign jr_ctx  = (opcode == OP_R) && (f3 == F3_JR) && (f7 == F7_JR_CTX);
  assign jr_so   = (opcode == OP_R) && (f3 == F3_JR) && (f7 == F7_JR_SO);
  assign tmo_hit = (st == S_WAIT_HD) && !hd_ready && (tmo_cnt == TW'(HD_TMO - 1));

  quantum_timer #(.QUANTUM(QUANTUM), .QW(QW)) u_quantum_timer (
    .clk           (clk),
    .rst_n         (rst_n),
    .user_mode     (user_mode),
    .reload        ((in_wb && jr_ctx) || (st == S_PREEMPT)),
    .clear_pending (st == S_PREEMPT),
    .yield_req     (in_wb && (opcode == OP_WAIT) && user_mode),
    .pending       (pending)
  );

  always_comb begin
    st_nx = st;
    case (st)
      S_FETCH:   st_nx = pending ? S_PREEMPT : S_DECODE;
      S_DECODE:  st_nx = S_EXEC;
      S_EXEC: begin
        if ((opcode == OP_R) && (f3 == F3_MD))               st_nx = S_WAIT_MD;
        else if ((opcode == OP_HD_RD) || (opcode == OP_HD_WR)) st_nx = S_WAIT_HD;
        else if (opcode == OP_IN)                             st_nx = S_WAIT_IN;
        else if (opcode == OP_HALT)                           st_nx = S_HALT;
        else                                                  st_nx = S_WB;
      end
      S_WAIT_MD: if (md_cnt == 4'(MD_LAT - 1)) st_nx = S_WB;
      S_WAIT_HD: if (hd_ready || tmo_hit) st_nx = S_WB;
      S_WAIT_IN: if (in_valid) st_nx = S_WB;
      S_WB:      st_nx = S_FETCH;
      S_PREEMPT: st_nx = S_FETCH;
      S_HALT:    st_nx = S_HALT;
      default:   st_nx = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st        <= S_FETCH;
      md_cnt    <= '0;
      tmo_cnt   <= '0;
      hd_fail   <= 1'b0;
      hd_err    <= 1'b0;
      user_mode <= 1'b0;
    end else begin
      st      <= st_nx;
      md_cnt  <= (st == S_WAIT_MD) ? md_cnt + 1'b1 : '0;
      tmo_cnt <= (st == S_WAIT_HD) ? tmo_cnt + 1'b1 : '0;
      if (tmo_hit) begin
        hd_err  <= 1'b1;
        hd_fail <= 1'b1;
      end else if (st == S_FETCH) begin
        hd_fail <= 1'b0;
      end
      if (in_wb && jr_ctx)                             user_mode <= 1'b1;
      else if ((in_wb && jr_so) || (st == S_PREEMPT))  user_mode <= 1'b0;
    end
  end

  // Strobes decode the registered state only; in_ack alone follows in_valid.
  always_comb begin
    ir_write  = rst_n && (st == S_FETCH) && !pending;
    pc_write  = rst_n && in_wb;
    reg_write = rst_n && in_wb && writes_reg(opcode, f3, f7, hd_fail);
    mem_write = rst_n && in_wb && (opcode == OP_SW);
    hd_req    = rst_n && (st == S_WAIT_HD);
    hd_we     = rst_n && (st == S_WAIT_HD) && (opcode == OP_HD_WR);
    in_ack    = rst_n && (st == S_WAIT_IN) && in_valid;
    preempt   = rst_n && (st == S_PREEMPT);
    halted    = (st == S_HALT);
    state     = st[2:0];
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: a cycle-level reference model predicts
// every fetch, disk request, write-back, preemption and halt event.
module tb_control_sequencer;

  localparam int Q   = 20;
  localparam int MDL = 4;
  localparam int TMO = 8;
  localparam int INF = 32'h3fffffff;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] f3 = '0;
  logic [6:0] f7 = '0;
  logic       hd_ready = 1'b0;
  logic       in_valid = 1'b0;
  logic       ir_write, pc_write, reg_write, mem_write, hd_req, hd_we, in_ack;
  logic       preempt, user_mode, halted, hd_err;
  logic [2:0] state;

  control_sequencer #(.QUANTUM(Q), .QW(16), .MD_LAT(MDL), .HD_TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .f3(f3), .f7(f7),
    .hd_ready(hd_ready), .in_valid(in_valid),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .mem_write(mem_write), .hd_req(hd_req), .hd_we(hd_we), .in_ack(in_ack),
    .preempt(preempt), .user_mode(user_mode), .halted(halted), .hd_err(hd_err),
    .state(state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int base = 0;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic int now();
    return cyc - base;
  endfunction

  typedef enum int {EV_FETCH, EV_HDREQ, EV_WB, EV_PRE, EV_HALT} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    int         cyc;
    logic [3:0] fl;
  } ev_t;

  ev_t sb[$];
  int  n_chk = 0;
  int  n_pass = 0;
  int  stray = 0;
  bit  mon_en = 1'b0;

  // Reference model state: next fetch cycle, cycle from which the preemption
  // request is visible, user mode and sticky disk error.
  int f_nx = 0;
  int pend_t = INF;
  bit um = 1'b0;
  bit herr = 1'b0;
  int halt_cyc = 0;

  task automatic chk(input string nm, input bit ok, input longint act, input longint exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, now());
  endtask

  function automatic void push(input ev_kind_t k, input int c, input logic [3:0] fl);
    ev_t e;
    e.kind = k; e.cyc = c; e.fl = fl;
    sb.push_back(e);
  endfunction

  task automatic observe(input ev_kind_t k, input logic [3:0] fl);
    ev_t e;
    if (sb.size() == 0) begin
      chk("unexpected_event_kind", 1'b0, k, -1);
      return;
    end
    e = sb.pop_front();
    n_chk++;
    if (e.kind == k && e.cyc == now()) n_pass++;
    else $display("FAIL event: got kind %0d at cycle %0d, expected kind %0d at cycle %0d",
                  k, now(), e.kind, e.cyc);
    if (e.kind == k && (k == EV_WB || k == EV_HDREQ || k == EV_PRE))
      chk("event_flags", fl == e.fl, fl, e.fl);
  endtask

  logic hd_req_q = 1'b0;
  logic halted_q = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (ir_write) observe(EV_FETCH, 4'd0);
      if (hd_req && !hd_req_q) observe(EV_HDREQ, {3'b0, hd_we});
      if (pc_write) observe(EV_WB, {reg_write, mem_write, user_mode, hd_err});
      if (preempt) observe(EV_PRE, {3'b0, user_mode});
      if (halted && !halted_q) observe(EV_HALT, 4'd0);
      if (((reg_write || mem_write) && !pc_write) || (hd_we && !hd_req)) stray++;
    end
    hd_req_q <= hd_req;
    halted_q <= halted;
  end

  task automatic wait_until(input int c);
    while (now() < c) @(negedge clk);
  endtask

  function automatic bit exp_rw(input logic [6:0] op, input logic [2:0] a3,
                                input logic [6:0] a7, input bit tmo);
    case (op)
      7'd51:                    return !(a3 == 3'd7 && a7 <= 7'd2);
      7'd3, 7'd19, 7'd111, 7'd55: return 1'b1;
      7'd62:                    return !tmo;
      default:                  return 1'b0;
    endcase
  endfunction

  task automatic run_instr(input int sel, input bit force_tmo);
    logic [6:0] op, a7;
    logic [2:0] a3;
    int f, w, d;
    bit tmo;
    op = 7'd51; a3 = 3'd0; a7 = 7'd0; d = 0; tmo = 1'b0;
    case (sel)
      0:  begin op = 7'd51;  a3 = 3'd0; end
      1:  begin op = 7'd51;  a3 = 3'd3; a7 = 7'd1; end
      2:  op = 7'd19;
      3:  begin op = 7'd3; a3 = 3'd2; end
      4:  begin op = 7'd35; a3 = 3'd2; end
      5:  op = 7'd99;
      6:  op = 7'd111;
      7:  op = 7'd23;
      8:  op = 7'd55;
      9:  op = 7'd61;
      10: op = 7'd62;
      11: op = 7'd60;
      12: begin op = 7'd51; a3 = 3'd7; a7 = 7'd0; end
      13: begin op = 7'd51; a3 = 3'd7; a7 = 7'd1; end
      14: begin op = 7'd51; a3 = 3'd7; a7 = 7'd2; end
      15: op = 7'd63;
      default: begin op = 7'd51; a3 = 3'd7; a7 = 7'd5; end
    endcase

    f = f_nx;
    if (pend_t <= f) begin
      push(EV_PRE, f + 1, {3'b0, um});
      um = 1'b0;
      pend_t = INF;
      f = f + 2;
    end
    push(EV_FETCH, f, 4'd0);

    if (op == 7'd51 && a3 == 3'd3) begin
      w = f + 3 + MDL;
    end else if (op == 7'd61 || op == 7'd62) begin
      tmo = force_tmo || ($urandom_range(0, 3) == 0);
      d = tmo ? 0 : $urandom_range(0, TMO - 1);
      push(EV_HDREQ, f + 3, {3'b0, (op == 7'd61)});
      w = tmo ? f + 3 + TMO : f + 4 + d;
      if (tmo) herr = 1'b1;
    end else if (op == 7'd55) begin
      d = $urandom_range(0, 4);
      w = f + 4 + d;
    end else if (op == 7'd63) begin
      push(EV_HALT, f + 3, 4'd0);
      halt_cyc = f + 3;
      w = -1;
    end else begin
      w = f + 3;
    end

    if (w >= 0) begin
      push(EV_WB, w, {exp_rw(op, a3, a7, tmo), (op == 7'd35), um, herr});
      if (op == 7'd51 && a3 == 3'd7 && a7 == 7'd1) begin
        if (pend_t > w) pend_t = w + 1 + Q;
        um = 1'b1;
      end else if (op == 7'd51 && a3 == 3'd7 && a7 == 7'd2) begin
        if (pend_t > w + 1) pend_t = INF;
        um = 1'b0;
      end else if (op == 7'd60 && um) begin
        if (pend_t > w + 1) pend_t = w + 1;
      end
      f_nx = w + 1;
    end

    wait_until(f);
    opcode = op; f3 = a3; f7 = a7;
    if ((op == 7'd61 || op == 7'd62) && !tmo) begin
      wait_until(f + 3 + d);
      hd_ready = 1'b1;
      wait_until(f + 4 + d);
      hd_ready = 1'b0;
    end else if (op == 7'd55) begin
      wait_until(f + 3 + d);
      in_valid = 1'b1;
      #1 chk("in_ack", in_ack == 1'b1, in_ack, 1);
      wait_until(f + 4 + d);
      in_valid = 1'b0;
    end
  endtask

  initial begin
    int sel;
    logic [7:0] outs;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", state == 3'd0, state, 0);
    chk("reset_flags", {user_mode, halted, hd_err} == 3'b000, {user_mode, halted, hd_err}, 0);
    outs = {ir_write, pc_write, reg_write, mem_write, hd_req, hd_we, in_ack, preempt};
    chk("reset_strobes", outs == 8'd0, outs, 0);

    @(posedge clk);
    #2;
    rst_n = 1'b1;
    base = cyc;
    mon_en = 1'b1;

    // Directed: add, mul, timed-out disk read, quantum expiry, yield and kernel WAIT.
    run_instr(0, 1'b0);
    run_instr(1, 1'b0);
    run_instr(10, 1'b1);
    run_instr(13, 1'b0);
    repeat (8) run_instr(0, 1'b0);
    run_instr(11, 1'b0);
    run_instr(13, 1'b0);
    run_instr(11, 1'b0);
    run_instr(0, 1'b0);

    for (int i = 0; i < 200; i++) begin
      sel = $urandom_range(0, 15);
      if (sel == 15) sel = 16;
      if (sel == 0 && $urandom_range(0, 1) == 1) sel = 13;
      run_instr(sel, 1'b0);
    end

    run_instr(15, 1'b0);
    wait_until(halt_cyc + 1);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      hd_ready = 1'($urandom_range(0, 1));
      in_valid = 1'($urandom_range(0, 1));
      #1;
      outs = {ir_write, pc_write, reg_write, mem_write, hd_req, hd_we, in_ack, preempt};
      chk("halt_hold", halted && outs == 8'd0 && state == 3'd7, {halted, state, outs}, 12'hf00);
    end
    hd_ready = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    mon_en = 1'b0;
    chk("scoreboard_drained", sb.size() == 0, sb.size(), 0);
    chk("stray_strobes", stray == 0, stray, 0);

    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("halt_reset_state", state == 3'd0 && !halted, {halted, state}, 0);
    chk("halt_reset_flags", {user_mode, hd_err} == 2'b00, {user_mode, hd_err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    opcode = 7'd62; f3 = 3'd0; f7 = 7'd0;
    #1 chk("post_reset_fetch", ir_write == 1'b1, ir_write, 1);

    // Reset arriving while waiting on the disk abandons the request.
    repeat (3) @(posedge clk);
    #1 chk("hd_wait_req", hd_req == 1'b1 && state == 3'd4, {hd_req, state}, 12);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 chk("hd_abort", hd_req == 1'b0 && state == 3'd0, {hd_req, state}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("hd_abort_no_err", hd_err == 1'b0 && state == 3'd1, {hd_err, state}, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter QUANTUM, default 1000: user-mode preemption quantum in cycles, range 2..2^QW-1.
REQ-002 Parameter QW, default 16: quantum counter width.
REQ-003 Parameter MD_LAT, default 4: mul/div execute latency in cycles, range 1..15.
REQ-004 Parameter HD_TMO, default 255: maximum cycles spent waiting on hd_ready before abort.
REQ-005 Ports, clock and reset first:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- opcode  in  7  decoded instruction opcode field.
- f3  in  3  funct3 field.
- f7  in  7  funct7 field.
- hd_ready  in  1  disk transfer-complete handshake.
- in_valid  in  1  switch-input confirm (IN).
- ir_write  out  1  latch instruction register.
- pc_write  out  1  update PC.
- reg_write  out  1  register file write strobe.
- mem_write  out  1  data memory write strobe.
- hd_req  out  1  disk request, held until ready or timeout.
- hd_we  out  1  disk direction: 1 = REG_TO_HD, 0 = HD_TO_REG.
- in_ack  out  1  IN value consumed.
- preempt  out  1  one-cycle context-save pulse.
- user_mode  out  1  1 = user process running.
- halted  out  1  sticky halt.
- hd_err  out  1  sticky disk timeout flag.
- state  out  3  current FSM state encoding.

Function
REQ-006 States: FETCH, DECODE, EXEC, WAIT_MD, WAIT_HD, WAIT_IN, WB, PREEMPT, HALT (9 states; state port carries the low 3 bits; HALT is encoded 3'b111 and PREEMPT shares 3'b110 with WAIT_IN only through the package constant table, which remains unambiguous because PREEMPT is exposed via preempt).
REQ-007 FETCH: ir_write=1 for exactly one cycle, then DECODE, unless a preemption is pending; if pending, go to PREEMPT instead, with ir_write=0.
REQ-008 DECODE -> EXEC, always one cycle.
REQ-009 EXEC branches on the instruction:
- opcode 51, f3 3 (mul/div) -> WAIT_MD.
- opcode 61 or 62 -> WAIT_HD.
- opcode 55 -> WAIT_IN.
- opcode 63 -> HALT.
- all others -> WB.
REQ-010 WAIT_MD: stay exactly MD_LAT cycles, then go to WB.
REQ-011 WAIT_HD:
- hd_req=1; hd_we=1 for opcode 61.
- On hd_ready -> WB.
- After HD_TMO cycles without hd_ready: set hd_err and go to WB with reg_write suppressed.
REQ-012 WAIT_IN: hold until in_valid=1; on that cycle in_ack=1, then go to WB.
REQ-013 WB:
- pc_write=1 for one cycle.
- reg_write=1 for R-type except jr/jr_ctx/jr_so, lw, addi, jal, IN, HD_TO_REG; mem_write=1 for opcode 35.
- Next state FETCH.
REQ-014 Mode and quantum counter:
- jr_ctx (51/7/1) in WB sets user_mode=1 and reloads the counter with QUANTUM.
- jr_so (51/7/2) in WB clears user_mode.
REQ-015 While user_mode=1 and the counter is nonzero, the counter decrements by 1 every cycle; reaching 0 sets the pending flag; the counter never wraps below 0.
REQ-016 WAIT (opcode 60) in WB, with user_mode=1, sets the pending flag immediately (yield); in kernel mode it is a NOP.
REQ-017 Expiry mid-instruction never interrupts; the pending flag is honoured only at the next FETCH.
REQ-018 PREEMPT: preempt=1 for one cycle, user_mode cleared, pending cleared, counter reloaded; then FETCH.
REQ-019 Simultaneous jr_ctx WB and counter expiry: the reload wins and the pending flag stays clear.
REQ-020 HALT: absorbing state; halted=1 and all strobes 0 until reset; pending preemption is ignored.
REQ-021 All strobe outputs are registered-state decodes: no combinational path from hd_ready or in_valid to any output other than in_ack.

Reset
REQ-022 rst_n=0 sampled on a rising edge gives:
- state=FETCH.
- user_mode=0, halted=0, hd_err=0, pending=0, counter=QUANTUM, MD and timeout counters=0.
- All strobes 0.
REQ-023 Reset mid-wait (any WAIT_* state) abandons the transaction; hd_req drops on the following cycle.

Structure
REQ-024 The shared package holds the state enum, the opcode constants (51, 3, 19, 99, 111, 35, 55, 23, 63, 62, 61, 60) and the f7 codes for jr, jr_ctx and jr_so.
REQ-025 One sub-module, quantum_timer, holds the counter, reload, decrement, pending flag and yield input.

Verification
REQ-026 Directed scenarios the bench must cover:
- add instruction -> FETCH, DECODE, EXEC, WB, FETCH; 4 cycles; reg_write=1 in WB only.
- mul with MD_LAT=4 -> exactly 4 cycles in WAIT_MD; pc_write on cycle 7.
- HD_TO_REG with hd_ready held low and HD_TMO=8 -> hd_err=1 after 8 cycles, reg_write=0, then FETCH.
- jr_ctx with QUANTUM=20, then a stream of adds -> preempt pulses at the first FETCH at or after cycle 20; user_mode=0 afterwards.
- WAIT in user mode -> preempt on the next FETCH; WAIT in kernel mode -> no preempt.
- HALT followed by in_valid/hd_ready toggling -> halted stays 1, strobes stay 0; rst_n=0 -> state=FETCH.
